flash_user_arbit: RTL and testbench
===================================

FLASH_USER_ARBIT -- requirements
Module: flash_user_arbit

Interface
REQ-001 SHALL have parameter U_DLY, default 1, register assignment delay in ns (simulation only).
REQ-002 SHALL have port clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port user_req  in  2  per-port access request, bit i = port i.
REQ-005 SHALL have port user_ack  out  2  one-cycle grant pulse per port.
REQ-006 SHALL have port user_done  in  2  per-port release pulse.
REQ-007 SHALL have port user_en  in  2  per-port command/data beat strobe.
REQ-008 SHALL have port user_cmd  in  64  port i at [32i+31:32i]: [31] 0=write/1=read, [23:16] length, [15:0] address.
REQ-009 SHALL have port user_wr_data  in  16  port i write byte at [8i+7:8i].
REQ-010 SHALL have port user_rd_data  out  8  read byte, shared by both ports.
REQ-011 SHALL have port user_rd_data_valid  out  2  read byte valid for port i.
REQ-012 SHALL have port flash_cmd_valid / flash_cmd_ready  out/in  1/1  flash engine command handshake.
REQ-013 SHALL have port flash_cmd  out  32  {rw, 7'd0, length[7:0], addr[15:0]}.
REQ-014 SHALL have port flash_wr_en / flash_wr_ready / flash_wr_data  out/in/out  1/1/8  write byte stream to the flash engine.
REQ-015 SHALL have port flash_rd_data / flash_rd_valid  in/in  8/1  read byte stream from the flash engine.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, ISSUE, WDATA, RDATA, FINISH.
REQ-017 SHALL in IDLE, with any user_req bit set, select a port, pulse its user_ack for exactly 1 cycle, and go to GRANT.
REQ-018 SHALL arbitrate round-robin: when both ports request, grant the port not served last; the last-served pointer resets to 1, so port 0 wins first.
REQ-019 SHALL ignore user_req, user_en and user_done of the non-granted port, and all user_req outside IDLE; no user_ack is produced for them.
REQ-020 SHALL in GRANT latch the granted port's rw, length and addr on its first user_en beat; if no beat occurred, latch them on user_done.
REQ-021 SHALL for writes store each user_en beat's byte into a 256x8 buffer at a beat index starting at 0, and discard beats beyond length.
REQ-022 SHALL for reads ignore user_en data bytes.
REQ-023 SHALL capture a user_en beat that coincides with user_done, then leave GRANT for ISSUE.
REQ-024 SHALL in ISSUE hold flash_cmd_valid=1 with flash_cmd stable until flash_cmd_ready=1 is sampled, then go to WDATA (write), RDATA (read), or FINISH when length=0.
REQ-025 SHALL in WDATA assert flash_wr_en while bytes remain, presenting buffer[index] combinationally; the index advances on flash_wr_en & flash_wr_ready; after exactly length transfers go to FINISH.
REQ-026 SHALL drive flash_wr_data to 8'hFF for buffer indices at or beyond the beat count received (short write).
REQ-027 SHALL in RDATA register each flash_rd_valid byte onto user_rd_data and pulse user_rd_data_valid[granted] 1 cycle later; after length bytes go to FINISH; flash_rd_valid outside RDATA is dropped.
REQ-028 SHALL in FINISH update the last-served pointer and return to IDLE after 1 cycle; the next grant is at the earliest the cycle after FINISH.
REQ-029 SHALL use 8-bit counters compared against length with no wrap; length=255 transfers 255 bytes.

Reset
REQ-030 SHALL on rst, at any point including mid-transfer, immediately force: state IDLE, user_ack=0, user_rd_data_valid=0, user_rd_data=0, flash_cmd_valid=0, flash_cmd=0, flash_wr_en=0, counters 0, last-served pointer=1; buffer contents need not be cleared.

Verification
REQ-031 SHALL cover: port 0 write, addr 16'h8080, length 4, bytes 11 22 33 44, ready tied 1 -> flash_cmd=32'h0004_8080, flash_wr_data 11,22,33,44 on 4 consecutive cycles, then IDLE.
REQ-032 SHALL cover: port 1 read, addr 16'h0010, length 3, engine returns AA BB CC -> user_rd_data_valid=2'b10 three times, 1 cycle after each flash_rd_valid, with bytes AA BB CC.
REQ-033 SHALL cover: user_req=2'b11 held for three transactions -> ack order port 0, port 1, port 0.
REQ-034 SHALL cover: write length 5 with only 2 beats (01 02), flash_wr_ready toggling -> stream 01 02 FF FF FF, with no byte lost or duplicated while ready=0.
REQ-035 SHALL cover: rst asserted in WDATA after 2 of 6 bytes -> all outputs 0 immediately; a new request after release is acked and served normally.
REQ-036 SHALL cover: length 0 write, and a user_en beat coincident with user_done -> FINISH straight after ISSUE with no flash_wr_en; the coincident beat is stored.

Source files
------------

// File: rtl/flash_user_arbit_if.sv
// Flash engine side of flash_user_arbit: command handshake, write byte stream
// and read byte stream, with arbiter (master) and engine (slave) views.
interface flash_user_arbit_if;
  logic        flash_cmd_valid;
  logic        flash_cmd_ready;
  logic [31:0] flash_cmd;
  logic        flash_wr_en;
  logic        flash_wr_ready;
  logic [7:0]  flash_wr_data;
  logic [7:0]  flash_rd_data;
  logic        flash_rd_valid;

  modport master (
    output flash_cmd_valid, flash_cmd, flash_wr_en, flash_wr_data,
    input  flash_cmd_ready, flash_wr_ready, flash_rd_data, flash_rd_valid
  );

  modport slave (
    input  flash_cmd_valid, flash_cmd, flash_wr_en, flash_wr_data,
    output flash_cmd_ready, flash_wr_ready, flash_rd_data, flash_rd_valid
  );
endinterface

// File: rtl/flash_user_arbit.sv
// Two-port round-robin arbiter in front of a flash command engine: buffers
// write beats, issues one command per grant and routes read bytes back.
module flash_user_arbit #(
  parameter int U_DLY = 1
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [1:0]         user_req,
  output logic [1:0]         user_ack,
  input  logic [1:0]         user_done,
  input  logic [1:0]         user_en,
  input  logic [63:0]        user_cmd,
  input  logic [15:0]        user_wr_data,
  output logic [7:0]         user_rd_data,
  output logic [1:0]         user_rd_data_valid,
  flash_user_arbit_if.master flash
);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WDATA, RDATA, FINISH} state_t;

  state_t      state;
  logic        gnt;
  logic        last;
  logic        got_cmd;
  logic        rw;
  logic [7:0]  len;
  logic [15:0] addr;
  logic [7:0]  beat_cnt;
  logic [7:0]  xfer_cnt;
  logic [7:0]  buffer [0:255];

  logic        next_port;
  logic        en_g;
  logic        done_g;
  logic        cmd_rw;
  logic [7:0]  cmd_len;
  logic [15:0] cmd_addr;
  logic [7:0]  byte_g;
  logic        rw_eff;
  logic [7:0]  len_eff;
  logic [15:0] addr_eff;
  logic        store;
  logic        unused_bits;

  assign unused_bits = ^{user_cmd[62:56], user_cmd[30:24], U_DLY};
  assign next_port   = (&user_req) ? ~last : user_req[1];

  // Before the command is latched, the live command of the granted port
  // governs the first beat, so that beat is judged by its own length.
  always_comb begin
    en_g     = user_en[gnt];
    done_g   = user_done[gnt];
    cmd_rw   = gnt ? user_cmd[63]    : user_cmd[31];
    cmd_len  = gnt ? user_cmd[55:48] : user_cmd[23:16];
    cmd_addr = gnt ? user_cmd[47:32] : user_cmd[15:0];
    byte_g   = gnt ? user_wr_data[15:8] : user_wr_data[7:0];
    rw_eff   = got_cmd ? rw   : cmd_rw;
    len_eff  = got_cmd ? len  : cmd_len;
    addr_eff = got_cmd ? addr : cmd_addr;
    store    = (state == GRANT) && en_g && !rw_eff && (beat_cnt < len_eff);
  end

  always_ff @(posedge clk_sys) begin
    if (store) buffer[beat_cnt] <= byte_g;
  end

  // Bytes past the received beat count read as erased flash.
  assign flash.flash_wr_data = !flash.flash_wr_en     ? '0 :
                               (xfer_cnt < beat_cnt) ? buffer[xfer_cnt] : 8'hFF;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      gnt                   <= 1'b0;
      last                  <= 1'b1;
      got_cmd               <= 1'b0;
      rw                    <= 1'b0;
      len                   <= '0;
      addr                  <= '0;
      beat_cnt              <= '0;
      xfer_cnt              <= '0;
      user_ack              <= '0;
      user_rd_data          <= '0;
      user_rd_data_valid    <= '0;
      flash.flash_cmd_valid <= 1'b0;
      flash.flash_cmd       <= '0;
      flash.flash_wr_en     <= 1'b0;
    end else begin
      user_ack           <= '0;
      user_rd_data_valid <= '0;
      case (state)
        IDLE: begin
          if (|user_req) begin
            gnt      <= next_port;
            user_ack <= next_port ? 2'b10 : 2'b01;
            got_cmd  <= 1'b0;
            beat_cnt <= '0;
            xfer_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!got_cmd && (en_g || done_g)) begin
            rw      <= cmd_rw;
            len     <= cmd_len;
            addr    <= cmd_addr;
            got_cmd <= 1'b1;
          end
          if (store) beat_cnt <= beat_cnt + 8'd1;
          if (done_g) begin
            flash.flash_cmd_valid <= 1'b1;
            flash.flash_cmd       <= {rw_eff, 7'd0, len_eff, addr_eff};
            state                 <= ISSUE;
          end
        end
        ISSUE: begin
          if (flash.flash_cmd_ready) begin
            flash.flash_cmd_valid <= 1'b0;
            if (len == 8'd0) begin
              state <= FINISH;
            end else if (rw) begin
              state <= RDATA;
            end else begin
              flash.flash_wr_en <= 1'b1;
              state             <= WDATA;
            end
          end
        end
        WDATA: begin
          if (flash.flash_wr_en && flash.flash_wr_ready) begin
            xfer_cnt <= xfer_cnt + 8'd1;
            if (xfer_cnt + 8'd1 == len) begin
              flash.flash_wr_en <= 1'b0;
              state             <= FINISH;
            end
          end
        end
        RDATA: begin
          if (flash.flash_rd_valid) begin
            user_rd_data       <= flash.flash_rd_data;
            user_rd_data_valid <= gnt ? 2'b10 : 2'b01;
            xfer_cnt           <= xfer_cnt + 8'd1;
            if (xfer_cnt + 8'd1 == len) state <= FINISH;
          end
        end
        FINISH: begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_user_arbit.sv
// Randomised scoreboard bench for flash_user_arbit: users and flash engine are
// modelled at transaction level; a monitor compares every observed output event.
`timescale 1ns/1ps
module tb_flash_user_arbit;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  user_req = '0, user_done = '0, user_en = '0;
  logic [63:0] user_cmd = '0;
  logic [15:0] user_wr_data = '0;
  logic [1:0]  user_ack, user_rd_data_valid;
  logic [7:0]  user_rd_data;

  flash_user_arbit_if fif();

  flash_user_arbit #(.U_DLY(1)) dut (
    .clk_sys(clk_sys), .rst(rst), .user_req(user_req), .user_ack(user_ack),
    .user_done(user_done), .user_en(user_en), .user_cmd(user_cmd),
    .user_wr_data(user_wr_data), .user_rd_data(user_rd_data),
    .user_rd_data_valid(user_rd_data_valid), .flash(fif)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int unsigned port;
    logic        rw;
    logic [7:0]  len;
    logic [15:0] addr;
    int unsigned nbeats;
    logic [7:0]  beat [0:259];
    logic [7:0]  rd [0:255];
    int unsigned mode;      // engine ready: 0 always, 1 random, 2 toggling
    bit          coincide;  // last beat shares its cycle with done
  } txn_t;

  typedef struct packed {
    logic [1:0]  v;
    logic [7:0]  d;
    logic [31:0] c;
  } rd_exp_t;

  txn_t        pq0[$], pq1[$], txq[$];
  int unsigned exp_ack[$];
  logic [31:0] exp_cmd[$];
  logic [7:0]  exp_wr[$];
  rd_exp_t     exp_rd[$];

  int n_cmp = 0, n_err = 0;
  int unsigned m_last = 1;
  int unsigned wr_seen = 0;
  bit abort = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input int unsigned port, input logic rw, input int unsigned len,
                              input logic [15:0] addr, input int unsigned nbeats,
                              input int unsigned mode, input bit coincide);
    txn_t t;
    t.port = port; t.rw = rw; t.len = 8'(len); t.addr = addr; t.nbeats = nbeats;
    t.mode = mode; t.coincide = coincide;
    for (int i = 0; i < 260; i++) t.beat[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) t.rd[i] = 8'($urandom);
    return t;
  endfunction

  task automatic push(input txn_t t);
    if (t.port == 0) pq0.push_back(t); else pq1.push_back(t);
  endtask

  task automatic noise(input int unsigned o);
    user_en[o]              = 1'($urandom);
    user_done[o]            = 1'($urandom);
    user_wr_data[8*o +: 8]  = 8'($urandom);
    user_cmd[32*o +: 32]    = $urandom;
  endtask

  task automatic do_txn(input txn_t t);
    int unsigned o = 1 - t.port;
    int unsigned gap;
    user_cmd[32*t.port +: 32] = {t.rw, 7'($urandom), t.len, t.addr};
    for (int b = 0; b < int'(t.nbeats); b++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        noise(o);
        user_en[t.port] = 1'b0; user_done[t.port] = 1'b0;
        @(posedge clk_sys); #1;
      end
      noise(o);
      user_en[t.port] = 1'b1;
      user_wr_data[8*t.port +: 8] = t.beat[b];
      user_done[t.port] = (b == int'(t.nbeats) - 1) && t.coincide;
      @(posedge clk_sys); #1;
      user_cmd[32*t.port +: 32] = $urandom;  // must already be latched
    end
    user_en[t.port] = 1'b0;
    if (!(t.nbeats > 0 && t.coincide)) begin
      noise(o);
      user_done[t.port] = 1'b1;
      @(posedge clk_sys); #1;
    end
    user_en = '0; user_done = '0;
    user_cmd[32*t.port +: 32] = $urandom;
  endtask

  // Reference arbitration: with both ports waiting, the one not served last wins.
  task automatic run_batch();
    int unsigned p;
    txn_t t;
    bit got;
    while (pq0.size() + pq1.size() > 0 && !abort) begin
      if (pq0.size() > 0 && pq1.size() > 0) p = (m_last == 0) ? 1 : 0;
      else p = (pq0.size() > 0) ? 0 : 1;
      user_req = {pq1.size() > 0, pq0.size() > 0};
      if (p == 0) t = pq0.pop_front(); else t = pq1.pop_front();
      t.port = p;
      exp_ack.push_back(p);
      exp_cmd.push_back({t.rw, 7'd0, t.len, t.addr});
      if (!t.rw)
        for (int i = 0; i < int'(t.len); i++)
          exp_wr.push_back(i < int'(t.nbeats) ? t.beat[i] : 8'hFF);
      txq.push_back(t);
      got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
        @(posedge clk_sys); #1;
        if (user_ack != 2'b00) got = 1;
      end
      if (!got) begin
        check("ack_timeout", 32'd0, 32'd1);
        abort = 1;
      end else begin
        user_req[p] = (p == 0) ? (pq0.size() > 0) : (pq1.size() > 0);
        do_txn(t);
        m_last = p;
      end
    end
    user_req = '0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int i = 0; i < 4000 && !empty; i++) begin
      @(negedge clk_sys);
      empty = (exp_ack.size() + exp_cmd.size() + exp_wr.size() + exp_rd.size()) == 0;
    end
    if (!empty) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_user_ack"}, 32'(user_ack), 32'd0);
    check({tag, "_rd_valid"}, 32'(user_rd_data_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(user_rd_data), 32'd0);
    check({tag, "_cmd_valid"}, 32'(fif.flash_cmd_valid), 32'd0);
    check({tag, "_cmd"}, fif.flash_cmd, 32'd0);
    check({tag, "_wr_en"}, 32'(fif.flash_wr_en), 32'd0);
    check({tag, "_wr_data"}, 32'(fif.flash_wr_data), 32'd0);
  endtask

  // Monitor: every output event pops and compares the oldest expectation.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk_sys);
      if (!rst) begin
        if (user_ack != 2'b00) begin
          if (exp_ack.size() == 0) check("ack_unexpected", 32'(user_ack), 32'd0);
          else check("ack", 32'(user_ack), 32'd1 << exp_ack.pop_front());
        end
        if (fif.flash_cmd_valid && fif.flash_cmd_ready) begin
          if (exp_cmd.size() == 0) check("cmd_unexpected", fif.flash_cmd, 32'hFFFF_FFFF);
          else check("flash_cmd", fif.flash_cmd, exp_cmd.pop_front());
        end
        if (fif.flash_wr_en && fif.flash_wr_ready) begin
          wr_seen++;
          if (exp_wr.size() == 0) check("wr_unexpected", 32'(fif.flash_wr_en), 32'd0);
          else check("wr_data", 32'(fif.flash_wr_data), 32'(exp_wr.pop_front()));
        end
        if (user_rd_data_valid != 2'b00) begin
          if (exp_rd.size() == 0) check("rd_unexpected", 32'(user_rd_data_valid), 32'd0);
          else begin
            e = exp_rd.pop_front();
            check("rd_valid", 32'(user_rd_data_valid), 32'(e.v));
            check("rd_data", 32'(user_rd_data), 32'(e.d));
            check("rd_cycle", cyc, e.c);
          end
        end
      end
    end
  end

  // Flash engine model: random/toggling ready, read bytes after a read command.
  txn_t        cur;
  int unsigned e_mode = 1, rd_left = 0, rd_idx = 0;
  initial begin
    fif.flash_cmd_ready = 1'b0; fif.flash_wr_ready = 1'b0;
    fif.flash_rd_valid = 1'b0;  fif.flash_rd_data = '0;
    forever begin
      @(negedge clk_sys);
      if (rst) rd_left = 0;
      else if (fif.flash_cmd_valid && fif.flash_cmd_ready && txq.size() > 0) begin
        cur = txq.pop_front();
        e_mode = cur.mode;
        if (cur.rw) begin rd_left = cur.len; rd_idx = 0; end
      end
      @(posedge clk_sys); #1;
      case (e_mode)
        0: begin fif.flash_cmd_ready = 1'b1; fif.flash_wr_ready = 1'b1; end
        2: begin fif.flash_cmd_ready = ~fif.flash_cmd_ready; fif.flash_wr_ready = ~fif.flash_wr_ready; end
        default: begin fif.flash_cmd_ready = 1'($urandom); fif.flash_wr_ready = 1'($urandom); end
      endcase
      if (rd_left > 0 && (e_mode == 0 || $urandom_range(0, 1) == 1)) begin
        fif.flash_rd_valid = 1'b1;
        fif.flash_rd_data  = cur.rd[rd_idx];
        exp_rd.push_back('{v: (cur.port == 1) ? 2'b10 : 2'b01, d: cur.rd[rd_idx], c: cyc + 1});
        rd_idx++; rd_left--;
      end else begin
        fif.flash_rd_valid = (rd_left == 0) && ($urandom_range(0, 7) == 0);
        fif.flash_rd_data  = 8'($urandom);
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int unsigned len, base;
    logic rw;
    repeat (3) @(posedge clk_sys);
    #1 check_quiet("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk_sys); #1;

    // Both ports kept requesting: grants alternate starting at port 0.
    t = mk(0, 1'b0, 4, 16'h8080, 4, 0, 0);
    t.beat[0] = 8'h11; t.beat[1] = 8'h22; t.beat[2] = 8'h33; t.beat[3] = 8'h44;
    push(t);
    t = mk(1, 1'b1, 3, 16'h0010, 1, 0, 0);
    t.rd[0] = 8'hAA; t.rd[1] = 8'hBB; t.rd[2] = 8'hCC;
    push(t);
    push(mk(0, 1'b0, 6, 16'h1234, 7, 1, 1));
    push(mk(1, 1'b1, 5, 16'h4321, 0, 1, 0));
    run_batch();

    // Short write, zero length with coincident beat, coincident store, 255 bytes.
    t = mk(0, 1'b0, 5, 16'h0500, 2, 2, 0);
    t.beat[0] = 8'h01; t.beat[1] = 8'h02;
    push(t);
    push(mk(1, 1'b0, 0, 16'h0000, 1, 1, 1));
    push(mk(0, 1'b0, 3, 16'h0300, 3, 1, 1));
    push(mk(1, 1'b1, 255, 16'hFFFF, 0, 1, 0));
    push(mk(0, 1'b0, 255, 16'hABCD, 255, 1, 0));
    run_batch();

    for (int n = 0; n < 30; n++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16);
      rw  = 1'($urandom);
      push(mk($urandom_range(0, 1), rw, len, 16'($urandom),
              rw ? $urandom_range(0, 2) : $urandom_range(0, len + 2), 1, 1'($urandom)));
    end
    run_batch();
    drain();

    // Reset in the middle of a write burst, after two of six bytes.
    base = wr_seen;
    push(mk(0, 1'b0, 6, 16'h0606, 6, 0, 0));
    run_batch();
    for (int i = 0; i < 2000 && wr_seen < base + 2; i++) @(negedge clk_sys);
    check("mid_write_bytes", wr_seen - base, 32'd2);
    @(posedge clk_sys); #1;
    rst = 1'b1;
    #1 check_quiet("mid_reset");
    exp_wr.delete(); txq.delete();
    m_last = 1;
    repeat (3) @(posedge clk_sys); #1;
    rst = 1'b0;
    @(posedge clk_sys); #1;
    push(mk(1, 1'b1, 3, 16'h0777, 0, 1, 0));
    push(mk(0, 1'b0, 2, 16'h0888, 2, 1, 0));
    run_batch();
    drain();

    check("left_ack", exp_ack.size(), 32'd0);
    check("left_cmd", exp_cmd.size(), 32'd0);
    check("left_wr", exp_wr.size(), 32'd0);
    check("left_rd", exp_rd.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
